// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-decode stage: format codes and
// the major opcodes recognised by the decoder.
package imm_pkg;

    // Encoding format reported alongside every decoded instruction.
    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_C   = 3'd6,
        FMT_ILL = 3'd7
    } fmt_e;

    // Major opcodes, inst[6:0].
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Handshake bundle of the immediate-decode stage: upstream valid/ready with
// instruction and PC, downstream valid/ready with the decoded entry, and flush.
// The master modport is the environment side, the slave modport the stage.
interface imm_decode_stage_if
    import imm_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            flush;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    fmt_e            out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_imm, out_fmt,
               out_target, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_imm, out_fmt,
               out_target, out_illegal
    );

endinterface

// File: rtl/imm_decode_comb.sv
// Purely combinational instruction classifier and immediate extractor.
// Optional compressed-instruction decode is enabled by defining IMM_RVC_EN;
// without it every encoding with inst[1:0] != 2'b11 is illegal.
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic signed [31:0] imm32;
    logic [6:0]         opcode;

    assign opcode = inst[6:0];

`ifdef IMM_RVC_EN
    logic [15:0] ci;
    logic [2:0]  cf3;

    assign ci  = inst[15:0];
    assign cf3 = ci[15:13];
`endif

    // Classify the encoding, then assemble its immediate as a signed 32-bit value.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
        fmt   = FMT_ILL;
        imm32 = '0;
        if (inst[1:0] == 2'b11) begin
            case (opcode)
                OPC_LUI, OPC_AUIPC:   fmt = FMT_U;
                OPC_JAL:              fmt = FMT_J;
                OPC_JALR, OPC_LOAD, OPC_OP_IMM,
                OPC_MISC_MEM, OPC_SYSTEM:
                                      fmt = FMT_I;
                OPC_OP_IMM_32:        fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
                OPC_STORE:            fmt = FMT_S;
                OPC_BRANCH:           fmt = FMT_B;
                OPC_OP:               fmt = FMT_R;
                OPC_OP_32:            fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
                default:              fmt = FMT_ILL;
            endcase

            case (fmt)
                FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
                FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                  inst[11:8], 1'b0};
                FMT_U:   imm32 = {inst[31:12], 12'b0};
                FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                  inst[30:21], 1'b0};
                default: imm32 = '0;
            endcase
        end else begin
`ifdef IMM_RVC_EN
            case (ci[1:0])
                2'b01: begin
                    case (cf3)
                        3'b000, 3'b010: begin
                            fmt   = FMT_C;
                            imm32 = {{26{ci[12]}}, ci[12], ci[6:2]};
                        end
                        3'b011: begin
                            if (ci[11:7] != 5'd0 && ci[11:7] != 5'd2) begin
                                fmt   = FMT_C;
                                imm32 = {{14{ci[12]}}, ci[12], ci[6:2], 12'b0};
                            end
                        end
                        3'b101: begin
                            fmt   = FMT_C;
                            imm32 = {{20{ci[12]}}, ci[12], ci[8], ci[10:9], ci[6],
                                     ci[7], ci[2], ci[11], ci[5:3], 1'b0};
                        end
                        3'b110, 3'b111: begin
                            fmt   = FMT_C;
                            imm32 = {{23{ci[12]}}, ci[12], ci[6:5], ci[2],
                                     ci[11:10], ci[4:3], 1'b0};
                        end
                        default: ;
                    endcase
                end
                2'b00: begin
                    if (cf3 == 3'b010 || cf3 == 3'b110) begin
                        fmt   = FMT_C;
                        imm32 = {25'b0, ci[5], ci[12:10], ci[6], 2'b0};
                    end
                end
                default: ;
            endcase
`endif
        end
    end

    assign illegal = (fmt == FMT_ILL);
    // Size cast of a signed value sign-extends to XLEN.
    assign imm     = XLEN'(imm32);

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage. Instructions are decoded on entry and
// held in a two-entry skid buffer (output register O, skid register K) so the
// stage sustains one instruction per cycle with a registered in_ready.
// Optional feature macro: IMM_RVC_EN (compressed-instruction decode).
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    imm_decode_stage_if.slave bus
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    entry_t          in_entry;

    entry_t o_q;
    entry_t k_q;
    logic   o_valid;
    logic   k_valid;
    logic   ready_q;

    logic   o_valid_d;
    logic   k_valid_d;
    logic   o_load_in;
    logic   o_load_k;
    logic   k_load;
    logic   accept;

    imm_decode_comb #(.XLEN(XLEN)) u_decode (
        .inst    (bus.in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign in_entry = '{
        inst:    bus.in_inst,
        pc:      bus.in_pc,
        imm:     dec_imm,
        target:  bus.in_pc + dec_imm,
        fmt:     dec_fmt,
        illegal: dec_illegal
    };

    assign accept = bus.in_valid && ready_q;

    // Buffer control: flush wins, then refill O from K or the input, else park input in K.
    always_comb begin
        o_valid_d = o_valid;
        k_valid_d = k_valid;
        o_load_in = 1'b0;
        o_load_k  = 1'b0;
        k_load    = 1'b0;
        if (bus.flush) begin
            o_valid_d = 1'b0;
            k_valid_d = 1'b0;
        end else if (!o_valid || bus.out_ready) begin
            // O is free this cycle; K, if full, is older than any input
            // (and the input cannot be accepted while K is full).
            if (k_valid) begin
                o_load_k  = 1'b1;
                o_valid_d = 1'b1;
                k_valid_d = 1'b0;
            end else if (accept) begin
                o_load_in = 1'b1;
                o_valid_d = 1'b1;
            end else begin
                o_valid_d = 1'b0;
            end
        end else if (accept) begin
            k_load    = 1'b1;
            k_valid_d = 1'b1;
        end
    end

    // Valid flags, ready and the output register, all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            o_valid <= 1'b0;
            k_valid <= 1'b0;
            ready_q <= 1'b1;
            o_q     <= '{inst: '0, pc: '0, imm: '0, target: '0,
                         fmt: FMT_R, illegal: 1'b0};
        end else begin
            o_valid <= o_valid_d;
            k_valid <= k_valid_d;
            ready_q <= !k_valid_d;
            if (o_load_k) begin
                o_q <= k_q;
            end else if (o_load_in) begin
                o_q <= in_entry;
            end
        end
    end

    // Skid register payload, loaded only when O is stalled.
    always_ff @(posedge clk) begin
        // NOTE: K's payload is never visible unless k_valid is set, so it carries no reset.
        if (k_load) begin
            k_q <= in_entry;
        end
    end

    assign bus.in_ready    = ready_q;
    assign bus.out_valid   = o_valid;
    assign bus.out_inst    = o_q.inst;
    assign bus.out_pc      = o_q.pc;
    assign bus.out_imm     = o_q.imm;
    assign bus.out_target  = o_q.target;
    assign bus.out_fmt     = o_q.fmt;
    assign bus.out_illegal = o_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: a 32-bit and a 64-bit instance share clock and
// reset. A vector table drives both in lockstep; scoreboards hold expected
// entries from acceptance until the output handshake. Hand-written sequences
// cover back-pressure, flush and asynchronous reset with both entries full.
// Compressed-instruction rows adapt to IMM_RVC_EN.
module tb_imm_decode_stage;
    import imm_pkg::*;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] imm64;
        fmt_e        fmt64;
        logic        ill64;
        logic [31:0] imm32;
        fmt_e        fmt32;
        logic        ill32;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] tgt;
        fmt_e        fmt;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out32  = 0;
    int n_out64  = 0;

    exp_t q32[$];
    exp_t q64[$];
    exp_t exp32_cur;
    exp_t exp64_cur;
    exp_t e32;
    exp_t e64;

    vec_t vecs[15];

    imm_decode_stage_if #(.XLEN(32)) b32 ();
    imm_decode_stage_if #(.XLEN(64)) b64 ();

    imm_decode_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    imm_decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t mk32(input logic [31:0] inst, input logic [31:0] pc,
                                  input logic [31:0] imm, input fmt_e f, input logic ill);
        exp_t e;
        logic [31:0] t;
        t     = pc + imm;
        e.inst = inst;
        e.pc   = 64'(pc);
        e.imm  = 64'(imm);
        e.tgt  = 64'(t);
        e.fmt  = f;
        e.ill  = ill;
        return e;
    endfunction

    function automatic exp_t mk64(input logic [31:0] inst, input logic [63:0] pc,
                                  input logic [63:0] imm, input fmt_e f, input logic ill);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        e.imm  = imm;
        e.tgt  = pc + imm;
        e.fmt  = f;
        e.ill  = ill;
        return e;
    endfunction

    task automatic cmp(input string tag, input exp_t e, input logic [31:0] inst,
                       input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] tgt,
                       input fmt_e f, input logic ill);
        check({tag, "_inst"},    64'(inst), 64'(e.inst));
        check({tag, "_pc"},      pc,        e.pc);
        check({tag, "_imm"},     imm,       e.imm);
        check({tag, "_target"},  tgt,       e.tgt);
        check({tag, "_fmt"},     64'(f),    64'(e.fmt));
        check({tag, "_illegal"}, 64'(ill),  64'(e.ill));
    endtask

    // Scoreboards: compare on output handshake, then record this cycle's accept.
    always @(negedge clk) begin
        if (rst_n) begin
            if (b32.out_valid && b32.out_ready) begin
                n_out32++;
                check("sb32_has_entry", 64'(q32.size() != 0), 64'd1);
                if (q32.size() != 0) begin
                    e32 = q32.pop_front();
                    cmp("out32", e32, b32.out_inst, 64'(b32.out_pc), 64'(b32.out_imm),
                        64'(b32.out_target), b32.out_fmt, b32.out_illegal);
                end
            end
            if (b32.flush) q32.delete();
            else if (b32.in_valid && b32.in_ready) q32.push_back(exp32_cur);

            if (b64.out_valid && b64.out_ready) begin
                n_out64++;
                check("sb64_has_entry", 64'(q64.size() != 0), 64'd1);
                if (q64.size() != 0) begin
                    e64 = q64.pop_front();
                    cmp("out64", e64, b64.out_inst, b64.out_pc, b64.out_imm,
                        b64.out_target, b64.out_fmt, b64.out_illegal);
                end
            end
            if (b64.flush) q64.delete();
            else if (b64.in_valid && b64.in_ready) q64.push_back(exp64_cur);
        end
    end

    // Offer one vector to both instances; returns 1 ns after the accepting edge.
    task automatic drive_pair(input vec_t v);
        bit done;
        done = 1'b0;
        b32.in_valid = 1'b1; b32.in_inst = v.inst; b32.in_pc = v.pc[31:0];
        b64.in_valid = 1'b1; b64.in_inst = v.inst; b64.in_pc = v.pc;
        exp32_cur = mk32(v.inst, v.pc[31:0], v.imm32, v.fmt32, v.ill32);
        exp64_cur = mk64(v.inst, v.pc, v.imm64, v.fmt64, v.ill64);
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            done = b32.in_ready && b64.in_ready;
            @(posedge clk);
            #1;
        end
        check("pair_accept", 64'(done), 64'd1);
        b32.in_valid = 1'b0;
        b64.in_valid = 1'b0;
    endtask

    // Offer one instruction to the 32-bit instance only.
    task automatic drive32(input logic [31:0] inst, input logic [31:0] pc,
                           input logic [31:0] imm, input fmt_e f);
        bit done;
        done = 1'b0;
        b32.in_valid = 1'b1; b32.in_inst = inst; b32.in_pc = pc;
        exp32_cur = mk32(inst, pc, imm, f, 1'b0);
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            done = b32.in_ready;
            @(posedge clk);
            #1;
        end
        check("drive32_accept", 64'(done), 64'd1);
        b32.in_valid = 1'b0;
    endtask

    initial begin
        int base;

        vecs[0]  = '{32'hFFF00093, 64'h100, 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0, 32'hFFFFFFFF, FMT_I, 1'b0};
        vecs[1]  = '{32'hFE000EE3, 64'h200, 64'hFFFFFFFFFFFFFFFC, FMT_B, 1'b0, 32'hFFFFFFFC, FMT_B, 1'b0};
        vecs[2]  = '{32'h123452B7, 64'h300, 64'h0000000012345000, FMT_U, 1'b0, 32'h12345000, FMT_U, 1'b0};
        vecs[3]  = '{32'h0000007F, 64'h400, 64'h0, FMT_ILL, 1'b1, 32'h0, FMT_ILL, 1'b1};
        vecs[4]  = '{32'hFFF0009B, 64'h500, 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0, 32'h0, FMT_ILL, 1'b1};
        vecs[5]  = '{32'hFE20AC23, 64'h600, 64'hFFFFFFFFFFFFFFF8, FMT_S, 1'b0, 32'hFFFFFFF8, FMT_S, 1'b0};
        vecs[6]  = '{32'h001000EF, 64'h700, 64'h800, FMT_J, 1'b0, 32'h800, FMT_J, 1'b0};
        vecs[7]  = '{32'hFFFFF06F, 64'h10, 64'hFFFFFFFFFFFFFFFE, FMT_J, 1'b0, 32'hFFFFFFFE, FMT_J, 1'b0};
        vecs[8]  = '{32'h80000097, 64'h1000, 64'hFFFFFFFF80000000, FMT_U, 1'b0, 32'h80000000, FMT_U, 1'b0};
        vecs[9]  = '{32'h003100B3, 64'h20, 64'h0, FMT_R, 1'b0, 32'h0, FMT_R, 1'b0};
        vecs[10] = '{32'h003100BB, 64'h24, 64'h0, FMT_R, 1'b0, 32'h0, FMT_ILL, 1'b1};
        vecs[11] = '{32'h02000093, 64'hFFFFFFF0, 64'h20, FMT_I, 1'b0, 32'h20, FMT_I, 1'b0};
        vecs[12] = '{32'h80012083, 64'h40, 64'hFFFFFFFFFFFFF800, FMT_I, 1'b0, 32'hFFFFF800, FMT_I, 1'b0};
`ifdef IMM_RVC_EN
        vecs[13] = '{32'h000050FD, 64'h30, 64'hFFFFFFFFFFFFFFFF, FMT_C, 1'b0, 32'hFFFFFFFF, FMT_C, 1'b0};
        vecs[14] = '{32'h000040C0, 64'h34, 64'h4, FMT_C, 1'b0, 32'h4, FMT_C, 1'b0};
`else
        vecs[13] = '{32'h000050FD, 64'h30, 64'h0, FMT_ILL, 1'b1, 32'h0, FMT_ILL, 1'b1};
        vecs[14] = '{32'h000040C0, 64'h34, 64'h0, FMT_ILL, 1'b1, 32'h0, FMT_ILL, 1'b1};
`endif

        rst_n = 1'b1;
        b32.flush = 1'b0; b32.in_valid = 1'b0; b32.in_inst = '0; b32.in_pc = '0; b32.out_ready = 1'b1;
        b64.flush = 1'b0; b64.in_valid = 1'b0; b64.in_inst = '0; b64.in_pc = '0; b64.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid",   64'(b32.out_valid),   64'd0);
        check("rst_in_ready",    64'(b32.in_ready),    64'd1);
        check("rst_out_imm",     64'(b32.out_imm),     64'd0);
        check("rst_out_target",  64'(b32.out_target),  64'd0);
        check("rst_out_pc",      64'(b32.out_pc),      64'd0);
        check("rst_out_inst",    64'(b32.out_inst),    64'd0);
        check("rst_out_fmt",     64'(b32.out_fmt),     64'(FMT_R));
        check("rst_out_illegal", 64'(b32.out_illegal), 64'd0);
        check("rst64_out_valid", 64'(b64.out_valid),   64'd0);
        check("rst64_in_ready",  64'(b64.in_ready),    64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table vectors, back to back, both instances.
        for (int i = 0; i < 15; i++) begin
            drive_pair(vecs[i]);
            check("lat1_out_valid", 64'(b32.out_valid), 64'd1);
            check("lat1_out_inst",  64'(b32.out_inst),  64'(vecs[i].inst));
        end
        repeat (3) @(posedge clk);
        #1;
        check("table_sb32_empty", 64'(q32.size()), 64'd0);
        check("table_sb64_empty", 64'(q64.size()), 64'd0);
        check("table_n_out32",    64'(n_out32),    64'd15);
        check("table_n_out64",    64'(n_out64),    64'd15);

        // Back-pressure: three back-to-back inputs with out_ready held low.
        base = n_out32;
        b32.out_ready = 1'b0;
        drive32(32'h00100093, 32'h800, 32'h1, FMT_I);
        check("bp_in_ready_1", 64'(b32.in_ready), 64'd1);
        drive32(32'h00200113, 32'h804, 32'h2, FMT_I);
        check("bp_in_ready_2", 64'(b32.in_ready), 64'd0);
        b32.in_valid = 1'b1; b32.in_inst = 32'h00300193; b32.in_pc = 32'h808;
        exp32_cur = mk32(32'h00300193, 32'h808, 32'h3, FMT_I, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("bp_stall_in_ready", 64'(b32.in_ready), 64'd0);
            check("bp_stall_inst",     64'(b32.out_inst), 64'h00100093);
            check("bp_stall_imm",      64'(b32.out_imm),  64'h1);
        end
        b32.out_ready = 1'b1;
        drive32(32'h00300193, 32'h808, 32'h3, FMT_I);
        repeat (3) @(posedge clk);
        #1;
        check("bp_n_out",     64'(n_out32 - base), 64'd3);
        check("bp_sb_empty",  64'(q32.size()),     64'd0);

        // Flush with both entries full.
        b32.out_ready = 1'b0;
        drive32(32'h00400213, 32'h900, 32'h4, FMT_I);
        drive32(32'h00500293, 32'h904, 32'h5, FMT_I);
        check("fl_full_in_ready", 64'(b32.in_ready), 64'd0);
        b32.flush = 1'b1;
        @(posedge clk);
        #1;
        b32.flush = 1'b0;
        check("fl_out_valid", 64'(b32.out_valid), 64'd0);
        check("fl_in_ready",  64'(b32.in_ready),  64'd1);
        // An input accepted during flush is discarded.
        b32.out_ready = 1'b1;
        b32.flush = 1'b1;
        drive32(32'h00600313, 32'h908, 32'h6, FMT_I);
        b32.flush = 1'b0;
        check("fl_accept_dropped", 64'(b32.out_valid), 64'd0);
        drive32(32'h00700393, 32'h90C, 32'h7, FMT_I);
        check("fl_recover_valid", 64'(b32.out_valid), 64'd1);
        check("fl_recover_inst",  64'(b32.out_inst),  64'h00700393);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle with both entries full.
        b32.out_ready = 1'b0;
        drive32(32'h00800413, 32'hA00, 32'h8, FMT_I);
        drive32(32'h00900493, 32'hA04, 32'h9, FMT_I);
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", 64'(b32.out_valid), 64'd0);
        check("ar_in_ready",  64'(b32.in_ready),  64'd1);
        check("ar_out_inst",  64'(b32.out_inst),  64'd0);
        q32.delete();
        q64.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        b32.out_ready = 1'b1;
        b32.in_valid = 1'b1; b32.in_inst = 32'hFFF00093; b32.in_pc = 32'h100;
        exp32_cur = mk32(32'hFFF00093, 32'h100, 32'hFFFFFFFF, FMT_I, 1'b0);
        @(posedge clk);
        #1;
        b32.in_valid = 1'b0;
        check("ar_first_valid",  64'(b32.out_valid),  64'd1);
        check("ar_first_target", 64'(b32.out_target), 64'hFF);
        @(posedge clk);
        #1;
        check("ar_sb_empty", 64'(q32.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
